clk_div_ctrl: RTL
=================

Name: clk_div_ctrl

Overview:
- Programmable clock-divider controller for the board clock CLOCK (100 MHz, 10 ns period).
- Generates the divided `slowclock` and a one-cycle `tick` enable.
- Accepts divide-ratio updates over a valid/ready handshake and applies them only at full-period boundaries, so `slowclock` never produces a runt pulse.
- Drives all slow-rate logic (display refresh, debouncers, counters) that currently hang off a fixed divider.

Parameters:
- WIDTH, 26, width of the half-period count.
- DEFAULT_HALF, 50_000_000, half-period in CLOCK cycles after reset (1 Hz `slowclock`). Must be nonzero and less than 2^WIDTH.

Ports:
- CLOCK  in  1  system clock; all logic on posedge.
- RESET  in  1  asynchronous, active-high reset.
- enable  in  1  run request. High: divider counts. Low: divider stopped.
- cfg_valid  in  1  new half-period offered.
- cfg_half  in  WIDTH  requested half-period in CLOCK cycles. 0 is illegal.
- cfg_ready  out  1  controller can accept a configuration.
- cfg_err  out  1  one-cycle pulse when an accepted `cfg_half` is 0.
- slowclock  out  1  divided clock, 50% duty.
- tick  out  1  one-cycle pulse on the cycle `slowclock` becomes 1.
- active_half  out  WIDTH  half-period currently in effect.

Behaviour:
- States:
  - STOPPED: reset state.
  - RUN
  - PENDING: running, with a config waiting to be applied.
- Reset values: state=STOPPED, cnt=0, slowclock=0, tick=0, cfg_err=0, active_half=DEFAULT_HALF, pending register=0. cfg_ready=1 combinationally from state.
- cfg_ready = 1 in STOPPED and RUN, 0 in PENDING.
- Handshake: transfer occurs on a posedge where cfg_valid & cfg_ready. cfg_half must stay stable while cfg_valid is high and cfg_ready is low.
- Zero config: a transfer with cfg_half==0 is consumed but discarded. cfg_err pulses the next cycle; state, active_half and cnt are unchanged.
- STOPPED:
  - Valid transfer: active_half <= cfg_half at that edge.
  - enable sampled high: go to RUN with cnt=0, slowclock=0.
- RUN, counting:
  - Each edge: if cnt==active_half-1, then cnt <= 0 and slowclock toggles. Otherwise cnt increments.
  - slowclock is high for active_half cycles and low for active_half cycles, giving period 2*active_half.
  - First rising edge of slowclock occurs active_half cycles after the edge that entered RUN.
- tick: registered. It is 1 exactly in the cycle after the edge where slowclock toggles 0->1, i.e. it coincides with slowclock's first high cycle.
- RUN + valid transfer: store cfg_half in the pending register and go to PENDING.
- PENDING:
  - Counting continues with the old active_half.
  - At the edge where cnt==active_half-1 and slowclock==1 (end of a full period, high->low): slowclock <= 0, cnt <= 0, active_half <= pending, state <= RUN.
  - The next period uses the new value in full.
- enable low in RUN or PENDING: next edge goes to STOPPED with cnt=0, slowclock=0, tick=0. A truncated high phase is accepted, since stop is explicit.
  - If stopping from PENDING, the pending value is applied to active_half on that edge.
- Simultaneous events:
  - enable low + transfer in RUN: stop wins and active_half <= cfg_half directly.
  - enable low + zero config: stop proceeds, cfg_err pulses, active_half is unchanged.
  - Period boundary + transfer in RUN: the boundary toggle happens normally, and the config goes to PENDING. It applies at the next full-period end, never at the current edge.
- active_half==1: slowclock toggles every edge (CLOCK/2) and tick fires every 2 cycles.
- Arithmetic: cnt is WIDTH bits unsigned. active_half-1 is computed in WIDTH bits; it cannot underflow because 0 is rejected.
- RESET asserted at any time: all registers return to reset values immediately and any pending config is discarded.

Decomposition:
- Package clk_div_pkg holds:
  - state enum {STOPPED, RUN, PENDING}
  - WIDTH default
  - DEFAULT_HALF default
- Sub-module half_cnt: WIDTH-bit counter with sync clear and a terminal flag (cnt==limit-1).
- The FSM, handshake, pending register and slowclock/tick flops stay in clk_div_ctrl.

Test Plan:
- DEFAULT_HALF=4, RESET pulse mid-cycle, then enable=1 -> outputs 0 during reset. slowclock rises 4 cycles after RUN entry, period 8, tick high 1 cycle per 8, active_half=4.
- Stopped, offer cfg_half=2, then enable=1 -> accepted at once, active_half=2, period 4.
- Running with half=4, offer cfg_half=1 mid high-phase -> cfg_ready drops. The current period completes at 8 cycles, then toggling every cycle, and cfg_ready returns to 1.
- Offer cfg_half=0 while running -> cfg_err pulses 1 cycle; period and active_half are unchanged.
- Running with half=3 and a pending config of 5, drop enable -> next edge slowclock=0, state STOPPED, active_half=5. Re-enable -> first rise after 5 cycles.
- Assert RESET while PENDING -> active_half returns to DEFAULT_HALF, cfg_ready=1, and the pending value is never applied.

Source files
------------

// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared state encoding and default sizing for the clock divider
package clk_div_pkg;
  typedef enum logic [1:0] {STOPPED, RUN, PENDING} state_t;
  localparam int WIDTH_DEF = 26;
  localparam int DEFAULT_HALF_DEF = 50_000_000;
endpackage

// File: rtl/half_cnt.sv
// half_cnt: half-period counter that wraps to zero at limit-1 and flags that cycle
module half_cnt import clk_div_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_term
);
  logic [WIDTH-1:0] r_cnt;
  assign o_term = r_cnt == i_limit - WIDTH'(1);
  // count up, returning to zero on clear or at the end of a half period
  always_ff @(posedge clk or posedge rst)
    if (rst) r_cnt <= '0;
    else r_cnt <= (i_clr || o_term) ? '0 : r_cnt + WIDTH'(1);
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable divider producing slowclock/tick with glitch-free ratio updates
module clk_div_ctrl import clk_div_pkg::*; #(
  parameter int WIDTH        = WIDTH_DEF,
  parameter int DEFAULT_HALF = DEFAULT_HALF_DEF
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             enable,
  input  logic             cfg_valid,
  input  logic [WIDTH-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             slowclock,
  output logic             tick,
  output logic [WIDTH-1:0] active_half
);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_HALF);
  state_t           r_state;
  logic             r_slow, r_tick, r_err;
  logic [WIDTH-1:0] r_active, r_pend;
  logic             w_xfer, w_zero, w_good, w_term;
  assign cfg_ready   = r_state != PENDING;
  assign w_xfer      = cfg_valid && cfg_ready;
  assign w_zero      = cfg_half == '0;
  assign w_good      = w_xfer && !w_zero;
  assign cfg_err     = r_err;
  assign slowclock   = r_slow;
  assign tick        = r_tick;
  assign active_half = r_active;
  half_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk    (CLOCK),
    .rst    (RESET),
    .i_clr  (!enable || r_state == STOPPED),
    .i_limit(r_active),
    .o_term (w_term)
  );
  // run/stop FSM with handshake, deferred ratio update and slowclock/tick flops
  always_ff @(posedge CLOCK or posedge RESET)
    if (RESET) begin
      r_state  <= STOPPED;
      r_slow   <= 1'b0;
      r_tick   <= 1'b0;
      r_err    <= 1'b0;
      r_active <= DEF;
      r_pend   <= '0;
    end else begin
      r_err <= w_xfer && w_zero;
      if (r_state == STOPPED) begin
        r_slow <= 1'b0;
        r_tick <= 1'b0;
        if (w_good) r_active <= cfg_half;
        if (enable) r_state <= RUN;
      end else if (!enable) begin
        r_state <= STOPPED;
        r_slow  <= 1'b0;
        r_tick  <= 1'b0;
        if (r_state == PENDING) r_active <= r_pend;
        else if (w_good) r_active <= cfg_half;
      end else begin
        r_tick <= w_term && !r_slow;
        if (w_term) r_slow <= !r_slow;
        if (r_state == PENDING && w_term && r_slow) begin
          r_active <= r_pend;
          r_state  <= RUN;
        end
        if (w_good) begin
          r_pend  <= cfg_half;
          r_state <= PENDING;
        end
      end
    end
endmodule
